// File: rtl/pc_fetch_seq.sv
// Multicycle fetch sequencer: owns the architectural PC, runs the imem req/ack
// handshake, holds the fetched word for decode and loads next-PC on retirement.
module pc_fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          TIMEOUT  = 16
) (
   input  logic        i_clk,
   input  logic        i_rst,
   // imem handshake: a read completes in any cycle where o_imem_req and
   // i_imem_ack are both high; once raised, o_imem_req stays high until ack.
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic        o_instr_valid,
   input  logic        i_ex_done,
   input  logic        i_stall,
   input  logic        i_halt,
   output logic [31:0] o_pc,
   input  logic [31:0] i_npc,
   output logic [31:0] o_retire_cnt,
   output logic        o_fetch_err,
   output logic [2:0]  o_state
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_WAIT_EX = 3'd1,
      S_UPDATE  = 3'd2,
      S_HALTED  = 3'd3,
      S_ERROR   = 3'd4
   } state_t;

   localparam int            TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

   state_t        r_state;
   logic [31:0]   r_pc;
   logic [31:0]   r_instr;
   logic          r_instr_valid;
   logic          r_imem_req;
   logic [31:0]   r_retire_cnt;
   logic          r_fetch_err;
   logic [TW-1:0] r_to_cnt;

   logic          w_npc_misaligned;

   assign w_npc_misaligned = |i_npc[1:0];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_FETCH;
         r_pc          <= RESET_PC;
         r_instr       <= 32'd0;
         r_instr_valid <= 1'b0;
         r_imem_req    <= 1'b0;
         r_retire_cnt  <= 32'd0;
         r_fetch_err   <= 1'b0;
         r_to_cnt      <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (r_imem_req) begin
                  // Request is committed: stall no longer matters until ack or timeout.
                  if (i_imem_ack) begin
                     r_instr       <= i_imem_rdata;
                     r_instr_valid <= 1'b1;
                     r_imem_req    <= 1'b0;
                     r_to_cnt      <= '0;
                     r_state       <= S_WAIT_EX;
                  end else if (r_to_cnt == TO_LAST) begin
                     r_fetch_err   <= 1'b1;
                     r_imem_req    <= 1'b0;
                     r_state       <= S_ERROR;
                  end else begin
                     r_to_cnt      <= r_to_cnt + 1'b1;
                  end
               end else begin
                  r_imem_req <= ~i_stall;
               end
            end

            S_WAIT_EX: begin
               if (i_ex_done) begin
                  r_state <= S_UPDATE;
               end
            end

            S_UPDATE: begin
               // pc is loaded even when npc is misaligned so the bad target is visible.
               r_pc          <= i_npc;
               r_retire_cnt  <= r_retire_cnt + 32'd1;
               r_instr_valid <= 1'b0;
               r_to_cnt      <= '0;
               if (w_npc_misaligned) begin
                  r_fetch_err <= 1'b1;
                  r_state     <= S_ERROR;
               end else if (i_halt) begin
                  r_state     <= S_HALTED;
               end else begin
                  r_imem_req  <= ~i_stall;
                  r_state     <= S_FETCH;
               end
            end

            S_HALTED, S_ERROR: begin
               r_state <= r_state;
            end

            default: begin
               r_imem_req    <= 1'b0;
               r_instr_valid <= 1'b0;
               r_state       <= S_ERROR;
            end
         endcase
      end
   end

   assign o_imem_req    = r_imem_req;
   assign o_imem_addr   = r_pc;
   assign o_instr       = r_instr;
   assign o_instr_valid = r_instr_valid;
   assign o_pc          = r_pc;
   assign o_retire_cnt  = r_retire_cnt;
   assign o_fetch_err   = r_fetch_err;
   assign o_state       = r_state;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: table of instruction records plus hand sequences for
// stall, imem timeout, misaligned npc, halt and mid-instruction reset.
module tb_pc_fetch_seq;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          TIMEOUT  = 16;
   localparam logic [2:0]  ST_FETCH = 3'd0, ST_WAIT = 3'd1, ST_UPD = 3'd2,
                           ST_HALT = 3'd3, ST_ERR = 3'd4;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack = 1'b0;
   logic [31:0] i_imem_rdata = 32'd0;
   logic [31:0] o_instr;
   logic        o_instr_valid;
   logic        i_ex_done = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_halt = 1'b0;
   logic [31:0] o_pc;
   logic [31:0] i_npc = 32'd0;
   logic [31:0] o_retire_cnt;
   logic        o_fetch_err;
   logic [2:0]  o_state;

   pc_fetch_seq #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
      .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
      .o_instr(o_instr), .o_instr_valid(o_instr_valid),
      .i_ex_done(i_ex_done), .i_stall(i_stall), .i_halt(i_halt),
      .o_pc(o_pc), .i_npc(i_npc), .o_retire_cnt(o_retire_cnt),
      .o_fetch_err(o_fetch_err), .o_state(o_state)
   );

   // clock / reset block
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   // scoreboard
   logic [31:0] exp_q[$];
   logic [31:0] exp_instr_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int last_acc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic [31:0] npc;
      logic        halt;
      int          ack_dly;
      int          ex_dly;
      logic        chk_cpi;
      logic [31:0] exp_addr;
      logic [31:0] exp_retire;
      logic [2:0]  exp_state;
   } vec_t;

   vec_t vecs[8];
   vec_t v;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset(input int n);
      i_rst = 1'b1;
      @(negedge clk);
      check("rst_req", {31'd0, o_imem_req}, 32'd0);
      check("rst_pc", o_pc, RESET_PC);
      check("rst_addr", o_imem_addr, RESET_PC);
      check("rst_valid", {31'd0, o_instr_valid}, 32'd0);
      check("rst_instr", o_instr, 32'd0);
      check("rst_retire", o_retire_cnt, 32'd0);
      check("rst_err", {31'd0, o_fetch_err}, 32'd0);
      check("rst_state", {29'd0, o_state}, {29'd0, ST_FETCH});
      repeat (n - 1) @(negedge clk);
      i_rst = 1'b0;
   endtask

   // driver: one full instruction through FETCH, WAIT_EX and UPDATE
   task automatic run_instr(input vec_t t);
      int w = 0;
      while (!o_imem_req && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!o_imem_req) begin
         check("req_wait", {31'd0, o_imem_req}, 32'd1);
         return;
      end
      exp_q.push_back(t.exp_addr);
      for (int k = 0; k < t.ack_dly; k++) begin
         i_stall = 1'($urandom_range(0, 1));
         check("req_held", {31'd0, o_imem_req}, 32'd1);
         @(negedge clk);
      end
      i_stall = 1'b0;
      i_imem_ack = 1'b1;
      i_imem_rdata = t.rdata;
      exp_instr_q.push_back(t.rdata);
      check("imem_addr", o_imem_addr, exp_q.pop_front());
      if (t.chk_cpi) check("cycles_per_instr", cyc - last_acc, 32'd3);
      last_acc = cyc;
      @(negedge clk);
      i_imem_ack = 1'b0;
      i_imem_rdata = $urandom;
      check("wait_state", {29'd0, o_state}, {29'd0, ST_WAIT});
      check("instr_valid", {31'd0, o_instr_valid}, 32'd1);
      check("instr", o_instr, exp_instr_q.pop_front());
      check("req_low_wait", {31'd0, o_imem_req}, 32'd0);
      for (int k = 0; k < t.ex_dly; k++) @(negedge clk);
      check("instr_stable", o_instr, t.rdata);
      i_ex_done = 1'b1;
      i_npc = t.npc;
      i_halt = t.halt;
      @(negedge clk);
      i_ex_done = 1'b0;
      check("upd_state", {29'd0, o_state}, {29'd0, ST_UPD});
      check("pc_before_upd", o_pc, t.exp_addr);
      @(negedge clk);
      i_halt = 1'b0;
      check("pc_after_upd", o_pc, t.npc);
      check("retire_cnt", o_retire_cnt, t.exp_retire);
      check("post_state", {29'd0, o_state}, {29'd0, t.exp_state});
      check("valid_cleared", {31'd0, o_instr_valid}, 32'd0);
      check("fetch_err", {31'd0, o_fetch_err}, {31'd0, t.exp_state == ST_ERR});
   endtask

   initial begin
      vecs[0] = '{$urandom, 32'h3004, 1'b0, 0, 0, 1'b0, 32'h3000, 32'd1, ST_FETCH};
      vecs[1] = '{$urandom, 32'h3008, 1'b0, 0, 0, 1'b1, 32'h3004, 32'd2, ST_FETCH};
      vecs[2] = '{$urandom, 32'h300C, 1'b0, 0, 0, 1'b1, 32'h3008, 32'd3, ST_FETCH};
      vecs[3] = '{$urandom, 32'h3010, 1'b0, 0, 0, 1'b1, 32'h300C, 32'd4, ST_FETCH};
      vecs[4] = '{$urandom, 32'h3040, 1'b0, 0, 0, 1'b1, 32'h3010, 32'd5, ST_FETCH};
      vecs[5] = '{$urandom, 32'h3044, 1'b0, $urandom_range(1, 5), $urandom_range(1, 4),
                  1'b0, 32'h3040, 32'd6, ST_FETCH};
      vecs[6] = '{$urandom, 32'h3100, 1'b0, 0, 3, 1'b0, 32'h3044, 32'd7, ST_FETCH};
      vecs[7] = '{$urandom, 32'h3104, 1'b0, 2, 0, 1'b0, 32'h3100, 32'd8, ST_FETCH};

      // sequential run, branch target, variable latencies
      do_reset(2);
      foreach (vecs[i]) run_instr(vecs[i]);

      // stall held entering FETCH; stray ack/ex_done must be ignored
      i_stall = 1'b1;
      do_reset(1);
      i_imem_ack = 1'b1;
      i_ex_done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_req", {31'd0, o_imem_req}, 32'd0);
         check("stall_pc", o_pc, RESET_PC);
         check("stall_state", {29'd0, o_state}, {29'd0, ST_FETCH});
         check("stall_valid", {31'd0, o_instr_valid}, 32'd0);
      end
      i_imem_ack = 1'b0;
      i_ex_done = 1'b0;
      i_stall = 1'b0;
      @(negedge clk);
      check("unstall_req", {31'd0, o_imem_req}, 32'd1);
      v = '{32'hDEAD_BEEF, 32'h3004, 1'b0, 3, 1, 1'b0, 32'h3000, 32'd1, ST_FETCH};
      run_instr(v);

      // imem ack withheld until timeout
      do_reset(2);
      @(negedge clk);
      for (int k = 1; k <= TIMEOUT; k++) begin
         check("to_req", {31'd0, o_imem_req}, 32'd1);
         check("to_err_low", {31'd0, o_fetch_err}, 32'd0);
         @(negedge clk);
      end
      check("to_err", {31'd0, o_fetch_err}, 32'd1);
      check("to_req_off", {31'd0, o_imem_req}, 32'd0);
      check("to_state", {29'd0, o_state}, {29'd0, ST_ERR});
      i_imem_ack = 1'b1;
      @(negedge clk);
      i_imem_ack = 1'b0;
      check("err_sticky", {29'd0, o_state}, {29'd0, ST_ERR});
      check("err_no_valid", {31'd0, o_instr_valid}, 32'd0);
      do_reset(1);

      // misaligned npc
      v = '{32'h1234_5678, 32'h3006, 1'b0, 0, 0, 1'b0, 32'h3000, 32'd1, ST_ERR};
      run_instr(v);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("mis_req", {31'd0, o_imem_req}, 32'd0);
         check("mis_pc", o_pc, 32'h3006);
      end

      // halt on second instruction
      do_reset(1);
      v = '{$urandom, 32'h3004, 1'b0, 0, 0, 1'b0, 32'h3000, 32'd1, ST_FETCH};
      run_instr(v);
      v = '{$urandom, 32'h3008, 1'b1, 0, 1, 1'b0, 32'h3004, 32'd2, ST_HALT};
      run_instr(v);
      i_ex_done = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("halt_req", {31'd0, o_imem_req}, 32'd0);
         check("halt_pc", o_pc, 32'h3008);
         check("halt_retire", o_retire_cnt, 32'd2);
         check("halt_state", {29'd0, o_state}, {29'd0, ST_HALT});
      end
      i_ex_done = 1'b0;

      // reset asserted in the middle of WAIT_EX
      do_reset(1);
      @(negedge clk);
      i_imem_ack = 1'b1;
      i_imem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      i_imem_ack = 1'b0;
      check("mid_valid", {31'd0, o_instr_valid}, 32'd1);
      i_rst = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", {31'd0, o_instr_valid}, 32'd0);
      check("mid_rst_pc", o_pc, RESET_PC);
      check("mid_rst_req", {31'd0, o_imem_req}, 32'd0);
      check("mid_rst_state", {29'd0, o_state}, {29'd0, ST_FETCH});
      i_rst = 1'b0;
      @(negedge clk);
      check("mid_rst_refetch", {31'd0, o_imem_req}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
